// File: rtl/controlador_busca_pkg.sv
// controlador_busca_pkg
// Shared definitions for the instruction-fetch path: FSM state encoding,
// default bus widths and the jump-target range check. Also reused by the
// decoder and the CPU top so every block agrees on the encoding.
package controlador_busca_pkg;

  typedef logic [1:0] estado_t;

  localparam estado_t OCIOSO  = 2'd0;
  localparam estado_t BUSCA   = 2'd1;
  localparam estado_t ENTREGA = 2'd2;
  localparam estado_t PARADO  = 2'd3;

  localparam int LARGURA_END_PADRAO   = 8;
  localparam int LARGURA_INSTR_PADRAO = 8;

  // True when endereco lies inside the program window [inicio, fim].
  // Arguments are widened to 32 bits so a zero lower bound does not
  // collapse into a constant comparison.
  function automatic logic endereco_valido(input logic [31:0] endereco,
                                           input logic [31:0] inicio,
                                           input logic [31:0] fim);
    return (endereco >= inicio) && (endereco <= fim);
  endfunction

endpackage

// File: rtl/controlador_busca_if.sv
// controlador_busca_if
// Bundles the fetch controller's command inputs, ROM bus and decoder
// handshake.
//   slave  : the fetch controller (drives ler_endereco, instrucao_out,
//            pc_out, instr_valida, ocupado, erro_salto)
//   master : the CPU/decoder/ROM side (drives iniciar, parar, salto_*,
//            instrucao_in, instr_pronta)
interface controlador_busca_if #(
  parameter int LARGURA_END   = 8,
  parameter int LARGURA_INSTR = 8
);
  logic                     iniciar;
  logic                     parar;
  logic                     salto_en;
  logic [LARGURA_END-1:0]   salto_endereco;
  logic [LARGURA_INSTR-1:0] instrucao_in;
  logic [LARGURA_END-1:0]   ler_endereco;
  logic [LARGURA_INSTR-1:0] instrucao_out;
  logic [LARGURA_END-1:0]   pc_out;
  logic                     instr_valida;
  logic                     instr_pronta;
  logic                     ocupado;
  logic                     erro_salto;

  modport slave (
    input  iniciar, parar, salto_en, salto_endereco, instrucao_in, instr_pronta,
    output ler_endereco, instrucao_out, pc_out, instr_valida, ocupado, erro_salto
  );

  modport master (
    output iniciar, parar, salto_en, salto_endereco, instrucao_in, instr_pronta,
    input  ler_endereco, instrucao_out, pc_out, instr_valida, ocupado, erro_salto
  );
endinterface

// File: rtl/controlador_busca_contador_pc.sv
// contador_pc
// Program counter with asynchronous reset to END_INICIAL.
//   clk, reset      : clock / async active-high reset
//   carregar        : load endereco_carga (highest priority)
//   endereco_carga  : load value (jump target, already clamped by caller)
//   incrementar     : advance to prox(pc), wrapping END_FINAL -> END_INICIAL
//   pc              : current program counter
module contador_pc #(
  parameter int LARGURA_END = 8,
  parameter int END_INICIAL = 0,
  parameter int END_FINAL   = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   carregar,
  input  logic [LARGURA_END-1:0] endereco_carga,
  input  logic                   incrementar,
  output logic [LARGURA_END-1:0] pc
);

  localparam logic [LARGURA_END-1:0] INICIO = LARGURA_END'(END_INICIAL);
  localparam logic [LARGURA_END-1:0] FIM    = LARGURA_END'(END_FINAL);

  logic [LARGURA_END-1:0] pc_reg;
  logic [LARGURA_END-1:0] prox;

  // Wrap happens on equality with FIM, so pc never steps past the window.
  assign prox = (pc_reg == FIM) ? INICIO : pc_reg + LARGURA_END'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= INICIO;
    end else if (carregar) begin
      pc_reg <= endereco_carga;
    end else if (incrementar) begin
      pc_reg <= prox;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/controlador_busca.sv
// controlador_busca
// Instruction-fetch sequencer. Drives the (combinational) ROM address from
// the PC, registers the returned instruction with its address and offers it
// to the decoder through a valid/ready handshake, one instruction per cycle
// when the decoder is always ready. Handles start, halt and jumps.
//   clk, reset : clock / async active-high reset
//   bus        : controlador_busca_if.slave (commands, ROM bus, decoder side)
module controlador_busca
  import controlador_busca_pkg::*;
#(
  parameter int LARGURA_END   = LARGURA_END_PADRAO,
  parameter int LARGURA_INSTR = LARGURA_INSTR_PADRAO,
  parameter int END_INICIAL   = 0,
  parameter int END_FINAL     = 31
) (
  input  logic               clk,
  input  logic               reset,
  controlador_busca_if.slave bus
);

  localparam logic [LARGURA_END-1:0] INICIO = LARGURA_END'(END_INICIAL);

  estado_t                  estado_reg, estado_next;
  logic                     valida_reg, valida_next;
  logic [LARGURA_INSTR-1:0] instr_reg, instr_next;
  logic [LARGURA_END-1:0]   pc_out_reg, pc_out_next;
  logic                     erro_reg, erro_next;
  logic                     ocupado_reg;

  logic                     pc_carregar;
  logic                     pc_incrementar;
  logic [LARGURA_END-1:0]   pc_carga;
  logic [LARGURA_END-1:0]   pc;
  logic                     salto_ok;

  contador_pc #(
    .LARGURA_END (LARGURA_END),
    .END_INICIAL (END_INICIAL),
    .END_FINAL   (END_FINAL)
  ) u_contador_pc (
    .clk            (clk),
    .reset          (reset),
    .carregar       (pc_carregar),
    .endereco_carga (pc_carga),
    .incrementar    (pc_incrementar),
    .pc             (pc)
  );

  assign salto_ok = endereco_valido(32'(bus.salto_endereco),
                                    32'(END_INICIAL), 32'(END_FINAL));

  always_comb begin
    estado_next    = estado_reg;
    valida_next    = valida_reg;
    instr_next     = instr_reg;
    pc_out_next    = pc_out_reg;
    erro_next      = 1'b0;
    pc_carregar    = 1'b0;
    pc_carga       = pc;
    pc_incrementar = 1'b0;

    case (estado_reg)
      OCIOSO: begin
        if (bus.iniciar) estado_next = BUSCA;
      end

      BUSCA, ENTREGA: begin
        if (bus.parar) begin
          // pc already points past the instruction in the output register,
          // so a handshake in this same cycle needs no extra pc update.
          valida_next = 1'b0;
          estado_next = PARADO;
        end else if (bus.salto_en) begin
          // Flush and refetch; an out-of-window target restarts the program.
          valida_next = 1'b0;
          estado_next = BUSCA;
          pc_carregar = 1'b1;
          if (salto_ok) begin
            pc_carga = bus.salto_endereco;
          end else begin
            pc_carga  = INICIO;
            erro_next = 1'b1;
          end
        end else if ((estado_reg == BUSCA) || bus.instr_pronta) begin
          // First fetch, or transfer with back-to-back refill.
          instr_next     = bus.instrucao_in;
          pc_out_next    = pc;
          valida_next    = 1'b1;
          pc_incrementar = 1'b1;
          estado_next    = ENTREGA;
        end
      end

      PARADO: begin
        valida_next = 1'b0;
        if (bus.iniciar) estado_next = BUSCA;
      end

      default: begin
        estado_next = OCIOSO;
        valida_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_reg  <= OCIOSO;
      valida_reg  <= 1'b0;
      instr_reg   <= '0;
      pc_out_reg  <= '0;
      erro_reg    <= 1'b0;
      ocupado_reg <= 1'b0;
    end else begin
      estado_reg  <= estado_next;
      valida_reg  <= valida_next;
      instr_reg   <= instr_next;
      pc_out_reg  <= pc_out_next;
      erro_reg    <= erro_next;
      ocupado_reg <= (estado_next == BUSCA) || (estado_next == ENTREGA);
    end
  end

  assign bus.ler_endereco  = pc;
  assign bus.instrucao_out = instr_reg;
  assign bus.pc_out        = pc_out_reg;
  assign bus.instr_valida  = valida_reg;
  assign bus.ocupado       = ocupado_reg;
  assign bus.erro_salto    = erro_reg;

endmodule

// File: tb/tb_controlador_busca.sv
// tb_controlador_busca
// Directed bench for controlador_busca: a vector table for start, stall,
// halt/resume and jumps, plus hand-written sequences for wrap-around and
// asynchronous reset mid-delivery.
module tb_controlador_busca;

  logic clk;
  logic reset;

  controlador_busca_if #(.LARGURA_END(8), .LARGURA_INSTR(8)) bus ();

  controlador_busca #(
    .LARGURA_END   (8),
    .LARGURA_INSTR (8),
    .END_INICIAL   (0),
    .END_FINAL     (31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Combinational ROM: mem[i] = i + 8'h10
  logic [7:0] rom [256];
  always_comb bus.instrucao_in = rom[bus.ler_endereco];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string nome, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nome, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iniciar;
    logic       parar;
    logic       salto_en;
    logic [7:0] salto_end;
    logic       pronta;
    logic       e_valida;
    logic       e_ocupado;
    logic       e_erro;
    logic [7:0] e_ler;
    logic       chk_dados;
    logic [7:0] e_instr;
    logic [7:0] e_pc;
  } vetor_t;

  localparam int NV = 22;
  vetor_t vetores [NV];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 8'h10);

    //           ini par sal end    rdy  val ocu err ler    chk instr  pc
    vetores[0]  = '{1, 0, 0, 8'd0,  1,   0,  1,  0,  8'd0,  0, 8'h00, 8'd0};  // OCIOSO -> BUSCA
    vetores[1]  = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd1,  1, 8'h10, 8'd0};  // first fetch
    vetores[2]  = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd2,  1, 8'h11, 8'd1};
    vetores[3]  = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd3,  1, 8'h12, 8'd2};
    vetores[4]  = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd4,  1, 8'h13, 8'd3};
    vetores[5]  = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd5,  1, 8'h14, 8'd4};
    vetores[6]  = '{1, 0, 0, 8'd0,  0,   1,  1,  0,  8'd5,  1, 8'h14, 8'd4};  // stall (iniciar ignored)
    vetores[7]  = '{0, 0, 0, 8'd0,  0,   1,  1,  0,  8'd5,  1, 8'h14, 8'd4};
    vetores[8]  = '{0, 0, 0, 8'd0,  0,   1,  1,  0,  8'd5,  1, 8'h14, 8'd4};
    vetores[9]  = '{0, 0, 0, 8'd0,  0,   1,  1,  0,  8'd5,  1, 8'h14, 8'd4};
    vetores[10] = '{0, 0, 0, 8'd0,  0,   1,  1,  0,  8'd5,  1, 8'h14, 8'd4};
    vetores[11] = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd6,  1, 8'h15, 8'd5};  // release stall
    vetores[12] = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd7,  1, 8'h16, 8'd6};
    vetores[13] = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd8,  1, 8'h17, 8'd7};
    vetores[14] = '{0, 1, 0, 8'd0,  0,   0,  0,  0,  8'd8,  0, 8'h00, 8'd0};  // halt, pc held
    vetores[15] = '{0, 0, 1, 8'd3,  0,   0,  0,  0,  8'd8,  0, 8'h00, 8'd0};  // jump ignored in PARADO
    vetores[16] = '{1, 0, 0, 8'd0,  0,   0,  1,  0,  8'd8,  0, 8'h00, 8'd0};  // resume -> BUSCA
    vetores[17] = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd9,  1, 8'h18, 8'd8};  // resumes at held pc
    vetores[18] = '{0, 0, 1, 8'd20, 1,   0,  1,  0,  8'd20, 0, 8'h00, 8'd0};  // jump in range + accept
    vetores[19] = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd21, 1, 8'h24, 8'd20};
    vetores[20] = '{0, 0, 1, 8'd40, 1,   0,  1,  1,  8'd0,  0, 8'h00, 8'd0};  // jump out of range
    vetores[21] = '{0, 0, 0, 8'd0,  1,   1,  1,  0,  8'd1,  1, 8'h10, 8'd0};  // erro_salto one cycle only
  end

  initial begin
    logic [7:0] exp_pc;
    logic [7:0] exp_ler;

    reset              = 1'b1;
    bus.iniciar        = 1'b0;
    bus.parar          = 1'b0;
    bus.salto_en       = 1'b0;
    bus.salto_endereco = 8'd0;
    bus.instr_pronta   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    check("reset_valida",  0, 32'(bus.instr_valida),  32'd0);
    check("reset_instr",   0, 32'(bus.instrucao_out), 32'd0);
    check("reset_pc_out",  0, 32'(bus.pc_out),        32'd0);
    check("reset_ler",     0, 32'(bus.ler_endereco),  32'd0);
    check("reset_ocupado", 0, 32'(bus.ocupado),       32'd0);
    check("reset_erro",    0, 32'(bus.erro_salto),    32'd0);
    $display("[TB] reset: valida=%0b ler=%0d ocupado=%0b",
             bus.instr_valida, bus.ler_endereco, bus.ocupado);

    // Table-driven section
    for (int i = 0; i < NV; i++) begin
      bus.iniciar        = vetores[i].iniciar;
      bus.parar          = vetores[i].parar;
      bus.salto_en       = vetores[i].salto_en;
      bus.salto_endereco = vetores[i].salto_end;
      bus.instr_pronta   = vetores[i].pronta;
      step();
      check("valida",  i, 32'(bus.instr_valida), 32'(vetores[i].e_valida));
      check("ocupado", i, 32'(bus.ocupado),      32'(vetores[i].e_ocupado));
      check("erro",    i, 32'(bus.erro_salto),   32'(vetores[i].e_erro));
      check("ler",     i, 32'(bus.ler_endereco), 32'(vetores[i].e_ler));
      if (vetores[i].chk_dados) begin
        check("instr",  i, 32'(bus.instrucao_out), 32'(vetores[i].e_instr));
        check("pc_out", i, 32'(bus.pc_out),        32'(vetores[i].e_pc));
      end
      $display("[TB] vec %0d: valida=%0b ocupado=%0b erro=%0b ler=%0d instr=%02h pc_out=%0d",
               i, bus.instr_valida, bus.ocupado, bus.erro_salto,
               bus.ler_endereco, bus.instrucao_out, bus.pc_out);
    end

    // Wrap-around: stream from pc_out=0 through 31 and back to 0
    bus.iniciar  = 1'b0;
    bus.parar    = 1'b0;
    bus.salto_en = 1'b0;
    bus.instr_pronta = 1'b1;
    exp_pc = 8'd0;
    for (int k = 0; k < 40; k++) begin
      exp_pc  = (exp_pc == 8'd31) ? 8'd0 : exp_pc + 8'd1;
      exp_ler = (exp_pc == 8'd31) ? 8'd0 : exp_pc + 8'd1;
      step();
      check("wrap_valida", k, 32'(bus.instr_valida),  32'd1);
      check("wrap_pc_out", k, 32'(bus.pc_out),        32'(exp_pc));
      check("wrap_instr",  k, 32'(bus.instrucao_out), 32'(exp_pc + 8'h10));
      check("wrap_ler",    k, 32'(bus.ler_endereco),  32'(exp_ler));
      $display("[TB] wrap %0d: pc_out=%0d instr=%02h ler=%0d",
               k, bus.pc_out, bus.instrucao_out, bus.ler_endereco);
    end

    // Asynchronous reset in the middle of ENTREGA, checked before next edge
    #2;
    reset = 1'b1;
    #1;
    check("areset_valida",  0, 32'(bus.instr_valida),  32'd0);
    check("areset_instr",   0, 32'(bus.instrucao_out), 32'd0);
    check("areset_pc_out",  0, 32'(bus.pc_out),        32'd0);
    check("areset_ler",     0, 32'(bus.ler_endereco),  32'd0);
    check("areset_ocupado", 0, 32'(bus.ocupado),       32'd0);
    $display("[TB] async reset: valida=%0b ler=%0d ocupado=%0b",
             bus.instr_valida, bus.ler_endereco, bus.ocupado);
    @(negedge clk);
    reset = 1'b0;

    // Stays idle without iniciar, even with instr_pronta high
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_valida",  k, 32'(bus.instr_valida), 32'd0);
      check("idle_ocupado", k, 32'(bus.ocupado),      32'd0);
      check("idle_ler",     k, 32'(bus.ler_endereco), 32'd0);
      $display("[TB] idle %0d: valida=%0b ocupado=%0b ler=%0d",
               k, bus.instr_valida, bus.ocupado, bus.ler_endereco);
    end

    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    step();
    check("restart_valida", 0, 32'(bus.instr_valida),  32'd1);
    check("restart_instr",  0, 32'(bus.instrucao_out), 32'h10);
    check("restart_pc_out", 0, 32'(bus.pc_out),        32'd0);
    $display("[TB] restart: valida=%0b instr=%02h pc_out=%0d",
             bus.instr_valida, bus.instrucao_out, bus.pc_out);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/controlador_busca.md
Name: controlador_busca

Overview:
- Instruction-fetch sequencer for the program ROM.
- Owns the program counter and drives the ROM read address. The ROM is combinational.
- Registers each fetched instruction into an output register with a valid/ready handshake toward the decoder.
- Handles start, halt, jumps and address wrap-around. Sits between the ROM and the decode/execute stage of the CPU.

Parameters:
LARGURA_END, 8, address width (matches ROM ler_endereco)
LARGURA_INSTR, 8, instruction width (matches ROM instrucao_out)
END_INICIAL, 0, first program address; reset value of PC
END_FINAL, 31, last valid program address; PC wraps to END_INICIAL after it

Ports:
clk  in  1  system clock, rising edge
reset  in  1  one clock; reset is asynchronous and active-high
iniciar  in  1  start/resume fetching (level, sampled in OCIOSO/PARADO)
parar  in  1  halt request
salto_en  in  1  jump request, single-cycle
salto_endereco  in  LARGURA_END  jump target
instrucao_in  in  LARGURA_INSTR  data from ROM instrucao_out
ler_endereco  out  LARGURA_END  address to ROM; equals current PC register
instrucao_out  out  LARGURA_INSTR  registered instruction to decoder
pc_out  out  LARGURA_END  address of instruction in instrucao_out
instr_valida  out  1  instrucao_out/pc_out valid
instr_pronta  in  1  decoder accepts when instr_valida & instr_pronta
ocupado  out  1  high in BUSCA/ENTREGA
erro_salto  out  1  one-cycle pulse: jump target outside [END_INICIAL, END_FINAL]

Behaviour:
- Reset (async, immediate, also mid-operation):
  - pc=END_INICIAL, estado=OCIOSO.
  - instr_valida=0, instrucao_out=0, pc_out=0, ocupado=0, erro_salto=0.
  - ler_endereco=END_INICIAL.
- ler_endereco = pc (registered, no combinational path from inputs).
- prox(pc) = END_INICIAL if pc==END_FINAL, else pc+1. Never exceeds END_FINAL.
- States:
  - OCIOSO: iniciar=1 -> BUSCA. All other inputs ignored.
  - BUSCA: at the clock edge, load instrucao_out<=instrucao_in, pc_out<=pc, instr_valida<=1, pc<=prox(pc); -> ENTREGA. Latency: one cycle from address present to instr_valida.
  - ENTREGA, instr_valida=1 & instr_pronta=0: instrucao_out, pc_out and pc hold stable.
  - ENTREGA, instr_pronta=1 (transfer): load the next instruction the same edge (instrucao_out<=instrucao_in, pc_out<=pc, pc<=prox(pc)). instr_valida stays 1. Sustained throughput is 1 instruction/cycle.
  - PARADO: instr_valida=0, ocupado=0. iniciar=1 -> BUSCA, resuming from the held pc (not reset). salto_en ignored.
- Priority in BUSCA/ENTREGA: parar > salto_en > instr_pronta.
  - parar: instr_valida<=0, -> PARADO. pc keeps its value; a handshake in the same cycle still counts as accepted, and pc then points past it.
  - salto_en: instr_valida<=0 (flush), pc<=salto_endereco, -> BUSCA. First valid instruction arrives 2 cycles after the salto_en edge.
  - salto_en in range with simultaneous instr_pronta: the current instruction counts as accepted, then the jump applies.
  - salto_endereco out of range: pc<=END_INICIAL, erro_salto=1 for one cycle, flush, -> BUSCA.
- iniciar in BUSCA/ENTREGA is ignored.
- ocupado = (estado==BUSCA || estado==ENTREGA), registered with the state.

Decomposition:
- Shared package/include: state encoding (OCIOSO=2'd0, BUSCA=2'd1, ENTREGA=2'd2, PARADO=2'd3) and default width constants (LARGURA_END, LARGURA_INSTR), reused by the decoder and CPU top.
- One sub-module, contador_pc: PC register with async reset, load (jump/clamped target), increment-with-wrap (prox) and hold; parameterised by END_INICIAL/END_FINAL.
- The FSM and output register stay in controlador_busca.

Test Plan:
1. Reset, then iniciar=1 for 1 cycle, instr_pronta=1 constant, ROM loaded with mem[i]=i+8'h10 -> ler_endereco 0,1,2,…; instr_valida rises 1 cycle after BUSCA; instrucao_out 8'h10,8'h11,… one per cycle, pc_out matching.
2. Run with instr_pronta=1 until pc_out=31 -> next pc_out=0, instrucao_out=8'h10 (wrap); ler_endereco never reaches 32.
3. instr_pronta=0 for 5 cycles at pc_out=4 -> instrucao_out=8'h14 and ler_endereco=5 held stable; on instr_pronta=1 the next is 8'h15.
4. salto_en=1, salto_endereco=20, with instr_pronta=1 in the same cycle -> instr_valida=0 next cycle, then pc_out=20/8'h24; same with salto_endereco=40 -> erro_salto pulse, pc_out=0.
5. parar at pc_out=7 -> instr_valida=0, ocupado=0, pc held; iniciar -> resumes at the held pc; salto_en in PARADO has no effect.
6. Assert reset mid-ENTREGA between clock edges -> all outputs return to reset values immediately (before the next edge); after release, the FSM stays OCIOSO until iniciar.
